nfc_cal_latch_gen: RTL and testbench
====================================

Name: nfc_cal_latch_gen

Overview:
- Command/address latch generator sitting directly upstream of the NAND PHY top.
- Drives its ACG-side output inputs (DQ, CE, WE, RE, CLE, ALE, output enables) to issue SDR-style command and address cycles.
- Takes a byte stream with valid/ready handshake, selects one target CE, and toggles WE per byte with programmable setup, pulse and hold timing in system-clock cycles.
- Each PHY signal carries 4 phase lanes per clock; this block drives all lanes of a signal to the same pin level.

Parameters:
- NumberOfWays, 4, number of CE targets; must match PHY.
- SetupCycles, 1, cycles CE/CLE/ALE/DQ are stable before WE falls; range 1..15.
- WELowCycles, 2, WE low cycles per byte; range 1..15.
- WEHighCycles, 2, minimum WE high cycles per byte; range 1..15.
- HoldCycles, 1, cycles CE/CLE/ALE are held after the final WE rise; range 1..15.

Ports:
- iSystemClock  in  1  system clock, SDR 100 MHz
- iModuleReset  in  1  synchronous, active-high reset
- iCmd_Valid  in  1  byte valid
- oCmd_Ready  out  1  byte accepted when Valid&&Ready
- iCmd_Data  in  8  command or address byte
- iCmd_IsAddr  in  1  1=address (ALE), 0=command (CLE)
- iCmd_Last  in  1  final byte of the operation
- iTargetID  in  max(1,clog2(NumberOfWays))  CE index; sampled on the first beat only
- oBusy  out  1  high from first accept until DONE inclusive
- oDone  out  1  one-cycle completion pulse
- oDQSOutEnable  out  1  constant 0
- oDQOutEnable  out  1  DQ pad output enable
- oDQStrobe  out  8  constant 0
- oDQ  out  32  {4{byte}}
- oChipEnable  out  2*NumberOfWays  pin level, active-low; bits [2w+1:2w] belong to way w
- oReadEnable  out  4  constant 4'hF (RE idle high)
- oWriteEnable  out  4  pin level of WE on all lanes
- oAddressLatchEnable  out  4  ALE on all lanes
- oCommandLatchEnable  out  4  CLE on all lanes

Behaviour:
- Reset values, and IDLE values:
  - oWriteEnable=4'hF, oReadEnable=4'hF, oCommandLatchEnable=0, oAddressLatchEnable=0.
  - oChipEnable=all ones, oDQ=0, oDQOutEnable=0.
  - oBusy=0, oDone=0, oCmd_Ready=0 during reset and 1 in IDLE.
- All outputs are registered. A single 4-bit cycle counter is reloaded on each state entry.
- State machine:
  - IDLE: Ready=1. On accept, latch data, kind, last and target; go to SETUP.
  - SETUP (SetupCycles): selected CE pair=2'b00; CLE or ALE = 4'hF per kind, the other 0; oDQ=byte; DQOE=1; WE high. Then go to WE_LOW.
  - WE_LOW (WELowCycles): WriteEnable=4'h0; CE, CLE/ALE and DQ held. Then go to WE_HIGH.
  - WE_HIGH (≥WEHighCycles): WE=4'hF.
    - If the current byte was Last: go to HOLD after the minimum.
    - Otherwise Ready=1 from the final minimum cycle onward and the state stalls (WE high, CE/CLE/ALE/DQ held) until accept.
    - On accept: same kind goes to WE_LOW with the new byte on oDQ; different kind goes to SETUP with the new latch signals.
  - HOLD (HoldCycles): CE/CLE/ALE/DQ/DQOE held.
  - DONE (1 cycle): CE all ones, CLE=ALE=0, DQOE=0, oDQ=0, oDone=1; then IDLE.
- Ready is never asserted outside IDLE and the WE_HIGH wait window.
- iTargetID is ignored after the first beat. An out-of-range ID selects no CE; the cycle timing still runs.
- Reset mid-operation: the next cycle shows reset values. No completion pulse is generated and no partial WE pulse is completed.
- Throughput for a same-kind stream with Valid held: one byte per WELowCycles+WEHighCycles cycles.

Test Plan:
- Reset, then accept cmd 0x70 at cycle 0 with target 0 and defaults:
  - cycle 1: CE[1:0]=00, CLE=F, oDQ=32'h70707070, DQOE=1.
  - cycles 2-3: WE=0. Cycles 4-5: WE=F. Cycle 6: HOLD.
  - cycle 7: oDone=1, CE=all ones. Cycle 8: Ready=1.
- Cmd 0x00, then 5 address bytes 0x01..0x05 with Valid held:
  - one extra SETUP cycle between the command and the first address, with ALE=F and CLE=0 there.
  - address bytes are spaced 4 cycles apart; exactly 6 WE low pulses in total.
- Stall: drop Valid for 10 cycles between addresses 2 and 3.
  - WE stays F, ALE stays F, oDQ holds 0x02, Ready=1 throughout.
  - address 3 resumes directly in WE_LOW.
- iTargetID=3 on the first beat, then 2 on later beats: only oChipEnable[7:6]=00 for the whole operation.
- Assert iModuleReset during WE_LOW of byte 2:
  - next cycle: WE=F, CE=all ones, DQOE=0, oBusy=0, and no oDone pulse.
  - a new operation is accepted normally afterwards.
- Parameters 3/1/1/2:
  - each WE low lasts 1 cycle and each high at least 1 cycle.
  - 3 setup cycles before the first WE low, 2 hold cycles after the last WE rise.

Source files
------------

// File: rtl/nfc_cal_latch_gen.sv
// Command/address latch generator for the NAND PHY.
// Takes a valid/ready byte stream and issues SDR CLE/ALE write cycles
// on one selected CE. WE setup, low, high and hold times are counted
// in system-clock cycles.
module nfc_cal_latch_gen #(
    parameter int unsigned NumberOfWays = 4,
    parameter int unsigned SetupCycles  = 1,
    parameter int unsigned WELowCycles  = 2,
    parameter int unsigned WEHighCycles = 2,
    parameter int unsigned HoldCycles   = 1,
    localparam int unsigned TidW = (NumberOfWays > 1) ? $clog2(NumberOfWays) : 1
) (
    input  logic                        iSystemClock,
    input  logic                        iModuleReset,
    input  logic                        iCmd_Valid,
    output logic                        oCmd_Ready,
    input  logic [7:0]                  iCmd_Data,
    input  logic                        iCmd_IsAddr,
    input  logic                        iCmd_Last,
    input  logic [TidW-1:0]             iTargetID,
    output logic                        oBusy,
    output logic                        oDone,
    output logic                        oDQSOutEnable,
    output logic                        oDQOutEnable,
    output logic [7:0]                  oDQStrobe,
    output logic [31:0]                 oDQ,
    output logic [2*NumberOfWays-1:0]   oChipEnable,
    output logic [3:0]                  oReadEnable,
    output logic [3:0]                  oWriteEnable,
    output logic [3:0]                  oAddressLatchEnable,
    output logic [3:0]                  oCommandLatchEnable
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WE_LOW,
        ST_WE_HIGH,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [3:0] SetupLd  = 4'(SetupCycles - 1);
    localparam logic [3:0] WELowLd  = 4'(WELowCycles - 1);
    localparam logic [3:0] WEHighLd = 4'(WEHighCycles - 1);
    localparam logic [3:0] HoldLd   = 4'(HoldCycles - 1);

    state_t                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [7:0]                  data_q, data_d;
    logic                        isaddr_q, isaddr_d;
    logic                        last_q, last_d;
    logic [TidW-1:0]             tgt_q, tgt_d;

    logic                        ready_q, ready_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        dqoe_q, dqoe_d;
    logic [31:0]                 dq_q, dq_d;
    logic [2*NumberOfWays-1:0]   ce_q, ce_d;
    logic [3:0]                  we_q, we_d;
    logic [3:0]                  ale_q, ale_d;
    logic [3:0]                  cle_q, cle_d;

    logic                        accept;
    logic                        active;

    // Next state, counter reload, byte latch and output decode. Outputs are
    // decoded from the next state so the registered pins line up with the state.
    always_comb begin
        accept   = iCmd_Valid && ready_q;
        state_d  = state_q;
        cnt_d    = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        data_d   = data_q;
        isaddr_d = isaddr_q;
        last_d   = last_q;
        tgt_d    = tgt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d   = iCmd_Data;
                    isaddr_d = iCmd_IsAddr;
                    last_d   = iCmd_Last;
                    tgt_d    = iTargetID;
                    state_d  = ST_SETUP;
                    cnt_d    = SetupLd;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_WE_LOW;
                    cnt_d   = WELowLd;
                end
            end
            ST_WE_LOW: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_WE_HIGH;
                    cnt_d   = WEHighLd;
                end
            end
            ST_WE_HIGH: begin
                if (cnt_q == 4'd0) begin
                    if (last_q) begin
                        state_d = ST_HOLD;
                        cnt_d   = HoldLd;
                    end else if (accept) begin
                        data_d   = iCmd_Data;
                        isaddr_d = iCmd_IsAddr;
                        last_d   = iCmd_Last;
                        if (iCmd_IsAddr == isaddr_q) begin
                            state_d = ST_WE_LOW;
                            cnt_d   = WELowLd;
                        end else begin
                            state_d = ST_SETUP;
                            cnt_d   = SetupLd;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active = (state_d == ST_SETUP) || (state_d == ST_WE_LOW) ||
                 (state_d == ST_WE_HIGH) || (state_d == ST_HOLD);

        ce_d = '1;
        for (int unsigned w = 0; w < NumberOfWays; w++) begin
            if (active && (tgt_d == TidW'(w))) begin
                ce_d[2*w +: 2] = 2'b00;
            end
        end

        cle_d   = (active && !isaddr_d) ? 4'hF : 4'h0;
        ale_d   = (active && isaddr_d) ? 4'hF : 4'h0;
        dq_d    = active ? {4{data_d}} : '0;
        dqoe_d  = active;
        we_d    = (state_d == ST_WE_LOW) ? 4'h0 : 4'hF;
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE) ||
                  ((state_d == ST_WE_HIGH) && (cnt_d == 4'd0) && !last_d);
    end

    // State, byte latch and registered pin levels; reset drops any partial cycle.
    always_ff @(posedge iSystemClock) begin
        if (iModuleReset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            isaddr_q <= 1'b0;
            last_q   <= 1'b0;
            tgt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dqoe_q   <= 1'b0;
            dq_q     <= '0;
            ce_q     <= '1;
            we_q     <= 4'hF;
            ale_q    <= 4'h0;
            cle_q    <= 4'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            isaddr_q <= isaddr_d;
            last_q   <= last_d;
            tgt_q    <= tgt_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dqoe_q   <= dqoe_d;
            dq_q     <= dq_d;
            ce_q     <= ce_d;
            we_q     <= we_d;
            ale_q    <= ale_d;
            cle_q    <= cle_d;
        end
    end

    assign oCmd_Ready          = ready_q;
    assign oBusy               = busy_q;
    assign oDone               = done_q;
    assign oDQSOutEnable       = 1'b0;
    assign oDQOutEnable        = dqoe_q;
    assign oDQStrobe           = '0;
    assign oDQ                 = dq_q;
    assign oChipEnable         = ce_q;
    assign oReadEnable         = 4'hF;
    assign oWriteEnable        = we_q;
    assign oAddressLatchEnable = ale_q;
    assign oCommandLatchEnable = cle_q;

endmodule

// File: tb/tb_nfc_cal_latch_gen.sv
// Directed bench for nfc_cal_latch_gen: default timing on one instance,
// 3/1/1/2 timing on a second instance sharing the data inputs.
module tb_nfc_cal_latch_gen;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        b_valid;
    logic [7:0]  data;
    logic        isaddr;
    logic        last;
    logic [1:0]  tid;

    logic        ready, busy, done, dqsoe, dqoe;
    logic [7:0]  strobe;
    logic [31:0] dq;
    logic [7:0]  ce;
    logic [3:0]  re, we, ale, cle;

    logic        b_ready, b_busy, b_done, b_dqsoe, b_dqoe;
    logic [7:0]  b_strobe;
    logic [31:0] b_dq;
    logic [7:0]  b_ce;
    logic [3:0]  b_re, b_we, b_ale, b_cle;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nfall = 0;
    int falls [16];
    logic [3:0] prev_we = 4'hF;

    nfc_cal_latch_gen #(
        .NumberOfWays(4), .SetupCycles(1), .WELowCycles(2),
        .WEHighCycles(2), .HoldCycles(1)
    ) dut (
        .iSystemClock(clk), .iModuleReset(rst),
        .iCmd_Valid(valid), .oCmd_Ready(ready), .iCmd_Data(data),
        .iCmd_IsAddr(isaddr), .iCmd_Last(last), .iTargetID(tid),
        .oBusy(busy), .oDone(done), .oDQSOutEnable(dqsoe),
        .oDQOutEnable(dqoe), .oDQStrobe(strobe), .oDQ(dq),
        .oChipEnable(ce), .oReadEnable(re), .oWriteEnable(we),
        .oAddressLatchEnable(ale), .oCommandLatchEnable(cle)
    );

    nfc_cal_latch_gen #(
        .NumberOfWays(4), .SetupCycles(3), .WELowCycles(1),
        .WEHighCycles(1), .HoldCycles(2)
    ) dut_b (
        .iSystemClock(clk), .iModuleReset(rst),
        .iCmd_Valid(b_valid), .oCmd_Ready(b_ready), .iCmd_Data(data),
        .iCmd_IsAddr(isaddr), .iCmd_Last(last), .iTargetID(tid),
        .oBusy(b_busy), .oDone(b_done), .oDQSOutEnable(b_dqsoe),
        .oDQOutEnable(b_dqoe), .oDQStrobe(b_strobe), .oDQ(b_dq),
        .oChipEnable(b_ce), .oReadEnable(b_re), .oWriteEnable(b_we),
        .oAddressLatchEnable(b_ale), .oCommandLatchEnable(b_cle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, log WE falls.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (we == 4'h0 && prev_we == 4'hF && nfall < 16) begin
            falls[nfall] = cyc;
            nfall++;
        end
        prev_we = we;
    endtask

    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(ready), 32'd1);
        tick();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; b_valid = 1'b0;
        data = 8'h00; isaddr = 1'b0; last = 1'b0; tid = 2'd0;
        tick(); tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_we",    32'(we),    32'hF);
        chk("rst_ce",    32'(ce),    32'hFF);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_dqoe",  32'(dqoe),  32'd0);
        rst = 1'b0;
        tick();

        // single command 0x70, target 0
        chk("t1_c0_ready", 32'(ready), 32'd1);
        data = 8'h70; isaddr = 1'b0; last = 1'b1; tid = 2'd0; valid = 1'b1;
        tick(); valid = 1'b0;
        chk("t1_c1_ce",   32'(ce),   32'hFC);
        chk("t1_c1_cle",  32'(cle),  32'hF);
        chk("t1_c1_ale",  32'(ale),  32'h0);
        chk("t1_c1_dq",   dq,        32'h70707070);
        chk("t1_c1_dqoe", 32'(dqoe), 32'd1);
        chk("t1_c1_we",   32'(we),   32'hF);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        chk("t1_re",      32'(re),   32'hF);
        chk("t1_const",   {23'd0, dqsoe, strobe}, 32'd0);
        tick(); chk("t1_c2_we", 32'(we), 32'h0);
        tick(); chk("t1_c3_we", 32'(we), 32'h0);
        tick(); chk("t1_c4_we", 32'(we), 32'hF);
        tick(); chk("t1_c5_we", 32'(we), 32'hF);
        chk("t1_c5_ready", 32'(ready), 32'd0);
        tick();
        chk("t1_c6_ce",   32'(ce),   32'hFC);
        chk("t1_c6_done", 32'(done), 32'd0);
        tick();
        chk("t1_c7_done", 32'(done), 32'd1);
        chk("t1_c7_ce",   32'(ce),   32'hFF);
        chk("t1_c7_dqoe", 32'(dqoe), 32'd0);
        chk("t1_c7_dq",   dq,        32'd0);
        chk("t1_c7_cle",  32'(cle),  32'h0);
        tick();
        chk("t1_c8_ready", 32'(ready), 32'd1);
        chk("t1_c8_busy",  32'(busy),  32'd0);
        chk("t1_c8_done",  32'(done),  32'd0);

        // command 0x00 then five address bytes, Valid held
        nfall = 0;
        data = 8'h00; isaddr = 1'b0; last = 1'b0; valid = 1'b1;
        wait_accept("t2_acc_cmd");
        chk("t2_cmd_cle", 32'(cle), 32'hF);
        data = 8'h01; isaddr = 1'b1;
        wait_accept("t2_acc_a1");
        chk("t2_setup_ale", 32'(ale), 32'hF);
        chk("t2_setup_cle", 32'(cle), 32'h0);
        chk("t2_setup_we",  32'(we),  32'hF);
        chk("t2_setup_dq",  dq,       32'h01010101);
        data = 8'h02;
        wait_accept("t2_acc_a2");
        chk("t2_a2_we", 32'(we), 32'h0);
        data = 8'h03;
        wait_accept("t2_acc_a3");
        data = 8'h04;
        wait_accept("t2_acc_a4");
        data = 8'h05; last = 1'b1;
        wait_accept("t2_acc_a5");
        valid = 1'b0; last = 1'b0;
        wait_done("t2_done");
        chk("t2_nfall", 32'(nfall), 32'd6);
        chk("t2_gap0", 32'(falls[1] - falls[0]), 32'd5);
        for (int i = 1; i < 5; i++) begin
            chk("t2_gap", 32'(falls[i+1] - falls[i]), 32'd4);
        end

        // stall between addresses 2 and 3
        data = 8'h80; isaddr = 1'b0; last = 1'b0; valid = 1'b1;
        wait_accept("t3_acc_cmd");
        data = 8'h01; isaddr = 1'b1;
        wait_accept("t3_acc_a1");
        data = 8'h02;
        wait_accept("t3_acc_a2");
        valid = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            chk("t3_stall_we",    32'(we),    32'hF);
            chk("t3_stall_ale",   32'(ale),   32'hF);
            chk("t3_stall_dq",    dq,         32'h02020202);
            chk("t3_stall_ready", 32'(ready), 32'd1);
            tick();
        end
        data = 8'h03; last = 1'b1; valid = 1'b1;
        tick();
        valid = 1'b0; last = 1'b0;
        chk("t3_resume_we", 32'(we), 32'h0);
        chk("t3_resume_dq", dq,      32'h03030303);
        wait_done("t3_done");

        // target 3 on first beat, 2 afterwards
        data = 8'h90; isaddr = 1'b0; last = 1'b0; tid = 2'd3; valid = 1'b1;
        wait_accept("t4_acc_cmd");
        chk("t4_ce_first", 32'(ce), 32'h3F);
        data = 8'h00; isaddr = 1'b1; last = 1'b1; tid = 2'd2;
        wait_accept("t4_acc_a");
        valid = 1'b0; last = 1'b0; tid = 2'd0;
        for (int n = 0; n < 30 && !done; n++) begin
            chk("t4_ce", 32'(ce), 32'h3F);
            tick();
        end
        chk("t4_done",    32'(done), 32'd1);
        chk("t4_done_ce", 32'(ce),   32'hFF);

        // reset during WE_LOW of byte 2
        data = 8'h60; isaddr = 1'b0; last = 1'b0; valid = 1'b1;
        wait_accept("t5_acc_cmd");
        data = 8'h11; isaddr = 1'b1;
        wait_accept("t5_acc_a");
        valid = 1'b0;
        tick();
        chk("t5_pre_we", 32'(we), 32'h0);
        rst = 1'b1;
        tick();
        chk("t5_rst_we",    32'(we),    32'hF);
        chk("t5_rst_ce",    32'(ce),    32'hFF);
        chk("t5_rst_dqoe",  32'(dqoe),  32'd0);
        chk("t5_rst_busy",  32'(busy),  32'd0);
        chk("t5_rst_done",  32'(done),  32'd0);
        chk("t5_rst_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("t5_post_done",  32'(done),  32'd0);
        chk("t5_post_ready", 32'(ready), 32'd1);
        data = 8'hFF; isaddr = 1'b0; last = 1'b1; tid = 2'd0; valid = 1'b1;
        wait_accept("t5_acc_new");
        valid = 1'b0; last = 1'b0;
        chk("t5_new_ce", 32'(ce), 32'hFC);
        wait_done("t5_new_done");

        // second instance, timing 3/1/1/2: cmd 0x30 then cmd 0x31 (last)
        tick();
        chk("t6_c0_ready", 32'(b_ready), 32'd1);
        data = 8'h30; isaddr = 1'b0; last = 1'b0; b_valid = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) begin
                data = 8'h31; last = 1'b1;
            end
            if (k == 6) begin
                b_valid = 1'b0;
            end
            chk("t6_we",    32'(b_we),    (k == 4 || k == 6) ? 32'h0 : 32'hF);
            chk("t6_ce",    32'(b_ce),    (k <= 9) ? 32'hFC : 32'hFF);
            chk("t6_ready", 32'(b_ready), (k == 5 || k == 11) ? 32'd1 : 32'd0);
            chk("t6_done",  32'(b_done),  (k == 10) ? 32'd1 : 32'd0);
            if (k == 1) chk("t6_dq_first",  b_dq, 32'h30303030);
            if (k == 6) chk("t6_dq_second", b_dq, 32'h31313131);
        end
        last = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
